// File: rtl/cmd_ctrl_pkg.sv
// rtl/cmd_ctrl_pkg.sv - command receiver states, width and opcodes shared with the decoder
// CMD_CHKSUM_EN adds the WAIT_CHK state for the trailing checksum byte.
package cmd_ctrl_pkg;

  localparam int CMD_W = 24;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_READ  = 8'h40;
  localparam logic [7:0] OP_WRITE = 8'hA5;
  localparam logic [7:0] OP_CFG   = 8'hC0;

  typedef enum logic [1:0] {
    WAIT_B0  = 2'd0,
    WAIT_B1  = 2'd1,
`ifdef CMD_CHKSUM_EN
    WAIT_B2  = 2'd2,
    WAIT_CHK = 2'd3
`else
    WAIT_B2  = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/cmd_tmr.sv
// rtl/cmd_tmr.sv - inter-byte timeout counter, saturating, terminal count at TIMEOUT_CYC-1
module cmd_tmr #(
  parameter int TIMEOUT_CYC = 1302000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  TC_VAL  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  MAX_VAL = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;

  // Holds at TIMEOUT_CYC rather than wrapping back into the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != MAX_VAL)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/cmd_rcv_ctrl.sv
// rtl/cmd_rcv_ctrl.sv - assembles UART bytes into 24-bit commands with inter-byte timeout
// CMD_CHKSUM_EN adds a fourth checksum byte that must bring the byte sum to zero.
module cmd_rcv_ctrl
  import cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1302000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  output logic        timeout,
  output logic        chk_err
);

  state_t           state_q, state_d;
  logic             ack_q;
  logic             accept;
  logic [7:0]       b0_q, b1_q;
  logic [CMD_W-1:0] cmd_q;
  logic             cmd_rdy_q;
  logic             done;
  logic             tmr_clr, tmr_tc;
  logic [7:0]       last_byte;
  logic             chk_bad;

  // ack_q resets high so no acknowledge can leave the block while in reset.
  assign accept = rx_rdy & ~ack_q;

`ifdef CMD_CHKSUM_EN
  logic [7:0] b2_q;
  logic [7:0] sum;
  assign sum       = b0_q + b1_q + b2_q + rx_data;
  assign last_byte = b2_q;
`else
  assign last_byte = rx_data;
`endif

  always_comb begin
    state_d    = state_q;
    clr_rx_rdy = 1'b0;
    timeout    = 1'b0;
    chk_bad    = 1'b0;
    done       = 1'b0;
    tmr_clr    = 1'b0;
    case (state_q)
      WAIT_B0: begin
        tmr_clr = 1'b1;
        if (accept) begin
          clr_rx_rdy = 1'b1;
          state_d    = WAIT_B1;
        end
      end
      WAIT_B1: begin
        if (accept) begin
          clr_rx_rdy = 1'b1;
          tmr_clr    = 1'b1;
          state_d    = WAIT_B2;
        end else if (tmr_tc) begin
          timeout = 1'b1;
          state_d = WAIT_B0;
        end
      end
      WAIT_B2: begin
        if (accept) begin
          clr_rx_rdy = 1'b1;
          tmr_clr    = 1'b1;
`ifdef CMD_CHKSUM_EN
          state_d    = WAIT_CHK;
`else
          done       = 1'b1;
          state_d    = WAIT_B0;
`endif
        end else if (tmr_tc) begin
          timeout = 1'b1;
          state_d = WAIT_B0;
        end
      end
`ifdef CMD_CHKSUM_EN
      WAIT_CHK: begin
        if (accept) begin
          clr_rx_rdy = 1'b1;
          tmr_clr    = 1'b1;
          state_d    = WAIT_B0;
          if (sum == 8'h00) begin
            done = 1'b1;
          end else begin
            chk_bad = 1'b1;
          end
        end else if (tmr_tc) begin
          timeout = 1'b1;
          state_d = WAIT_B0;
        end
      end
`endif
      default: begin
        tmr_clr = 1'b1;
        state_d = WAIT_B0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_B0;
      ack_q     <= 1'b1;
      b0_q      <= 8'h00;
      b1_q      <= 8'h00;
`ifdef CMD_CHKSUM_EN
      b2_q      <= 8'h00;
`endif
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= clr_rx_rdy;
      if (clr_rx_rdy && (state_q == WAIT_B0)) b0_q <= rx_data;
      if (clr_rx_rdy && (state_q == WAIT_B1)) b1_q <= rx_data;
`ifdef CMD_CHKSUM_EN
      if (clr_rx_rdy && (state_q == WAIT_B2)) b2_q <= rx_data;
`endif
      if (done) cmd_q <= {b0_q, b1_q, last_byte};
      // Completion wins over both the consumer acknowledge and a new first byte.
      if (done) begin
        cmd_rdy_q <= 1'b1;
      end else if ((clr_rx_rdy && (state_q == WAIT_B0)) || clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end
    end
  end

  cmd_tmr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (state_q != WAIT_B0),
    .tc    (tmr_tc)
  );

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
`ifdef CMD_CHKSUM_EN
  assign chk_err = chk_bad;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_rcv_ctrl.sv
// tb/tb_cmd_rcv_ctrl.sv - directed vector bench for cmd_rcv_ctrl with TIMEOUT_CYC=50
// Honours CMD_CHKSUM_EN by appending the checksum byte and running the mismatch case.
module tb_cmd_rcv_ctrl;
  import cmd_ctrl_pkg::*;

  localparam int TO = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_rdy = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             clr_cmd_rdy = 1'b0;
  logic             clr_rx_rdy;
  logic [CMD_W-1:0] cmd;
  logic             cmd_rdy;
  logic             timeout;
  logic             chk_err;

  int total = 0;
  int bad = 0;
  int n_ack = 0, n_to = 0, n_chk = 0, n_dbl = 0;
  logic prev_ack = 1'b0;

  always #10 clk = ~clk;

  cmd_rcv_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .timeout     (timeout),
    .chk_err     (chk_err)
  );

  always @(negedge clk) begin
    if (clr_rx_rdy) n_ack++;
    if (clr_rx_rdy && prev_ack) n_dbl++;
    prev_ack = clr_rx_rdy;
    if (timeout) n_to++;
    if (chk_err) n_chk++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input logic clr);
    @(posedge clk);
    #1;
    rx_rdy      = 1'b1;
    rx_data     = b;
    clr_cmd_rdy = clr;
    repeat (hold) @(posedge clk);
    #1;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

`ifdef CMD_CHKSUM_EN
  localparam int NB = 4;
  function automatic logic [7:0] chk_of(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] s;
    s = a + b + c;
    return 8'h00 - s;
  endfunction
`else
  localparam int NB = 3;
`endif

  task automatic send_tail(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic clr);
`ifdef CMD_CHKSUM_EN
    send_byte(chk_of(b0, b1, b2), 1, clr);
`else
    if (b0 == b1 && b1 == b2 && clr === 1'bx) $display("unreachable");
`endif
  endtask

  task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1, 1'b0);
    send_byte(b1, 1, 1'b0);
    send_byte(b2, 1, 1'b0);
    send_tail(b0, b1, b2, 1'b0);
  endtask

  typedef struct {
    logic [7:0]       b0;
    logic [7:0]       b1;
    logic [7:0]       b2;
    int               gap;
    logic             clr_last;
    logic [CMD_W-1:0] exp_cmd;
    logic             exp_rdy;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [CMD_W-1:0] exp_prev;
    int a0, t0, c0, first;
    vec_t v;

    vt[0] = '{OP_WRITE, 8'h12, 8'h34, 28, 1'b0, 24'hA51234, 1'b1};
    vt[1] = '{8'h01,    8'h02, 8'h03, 2,  1'b1, 24'h010203, 1'b1};
    vt[2] = '{OP_CFG,   8'h00, 8'h01, 0,  1'b0, 24'hC00001, 1'b1};
    vt[3] = '{OP_NOP,   8'hFF, 8'h80, 5,  1'b1, 24'h00FF80, 1'b1};

    // reset state, with rx_rdy held high to show no acknowledge escapes
    rx_rdy = 1'b1;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_cmd", cmd, 24'h000000);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_clr_rx_rdy", clr_rx_rdy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_chk_err", chk_err, 0);
    rx_rdy = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    exp_prev = 24'h000000;
    for (int i = 0; i < 4; i++) begin
      v  = vt[i];
      a0 = n_ack;
      send_byte(v.b0, 1, 1'b0);
      settle();
      chk("vec_shadow_cmd", cmd, exp_prev);
      chk("vec_first_clears_rdy", cmd_rdy, 0);
      repeat (v.gap) @(posedge clk);
      send_byte(v.b1, 1, 1'b0);
      repeat (v.gap) @(posedge clk);
`ifdef CMD_CHKSUM_EN
      send_byte(v.b2, 1, 1'b0);
      repeat (v.gap) @(posedge clk);
      send_tail(v.b0, v.b1, v.b2, v.clr_last);
`else
      send_byte(v.b2, 1, v.clr_last);
`endif
      settle();
      chk("vec_cmd", cmd, v.exp_cmd);
      chk("vec_cmd_rdy", cmd_rdy, v.exp_rdy);
      chk("vec_ack_count", n_ack - a0, NB);
      exp_prev = v.exp_cmd;
    end
    chk("vec_no_timeout", n_to, 0);

    // consumer acknowledge alone clears cmd_rdy, cmd held
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
    settle();
    chk("clr_cmd_rdy", cmd_rdy, 0);
    chk("clr_cmd_hold", cmd, 24'h00FF80);

    // rx_rdy held two cycles: one acknowledge, one capture
    a0 = n_ack;
    send_byte(OP_WRITE, 2, 1'b0);
    send_byte(8'h12, 1, 1'b0);
    send_byte(8'h34, 1, 1'b0);
    send_tail(OP_WRITE, 8'h12, 8'h34, 1'b0);
    settle();
    chk("hold_cmd", cmd, 24'hA51234);
    chk("hold_ack_count", n_ack - a0, NB);

    // two bytes then silence: timeout on the 50th cycle after the last capture
    t0 = n_to;
    send_byte(OP_READ, 1, 1'b0);
    send_byte(8'h11, 1, 1'b0);
    first = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      #1;
      if (timeout && first == 0) first = k;
    end
    chk("to_cycle", first, TO);
    chk("to_count", n_to - t0, 1);
    chk("to_cmd_hold", cmd, 24'hA51234);
    chk("to_rdy_hold", cmd_rdy, 0);
    send_cmd(8'h12, 8'h34, 8'h56);
    settle();
    chk("to_back_in_b0", cmd, 24'h123456);

    // byte arriving in the terminal-count cycle wins over the timeout
    t0 = n_to;
    send_byte(OP_READ, 1, 1'b0);
    send_byte(8'h11, 1, 1'b0);
    repeat (TO - 2) @(posedge clk);
    send_byte(8'h22, 1, 1'b0);
    send_tail(OP_READ, 8'h11, 8'h22, 1'b0);
    settle();
    chk("race_no_timeout", n_to - t0, 0);
    chk("race_cmd", cmd, 24'h401122);
    chk("race_rdy", cmd_rdy, 1);

    // reset mid-command discards partial bytes
    send_byte(8'h55, 1, 1'b0);
    send_byte(8'h66, 1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    settle();
    chk("midrst_cmd", cmd, 24'h000000);
    chk("midrst_rdy", cmd_rdy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    t0 = n_to;
    send_cmd(OP_CFG, 8'h00, 8'h01);
    settle();
    chk("midrst_new_cmd", cmd, 24'hC00001);
    chk("midrst_new_rdy", cmd_rdy, 1);
    repeat (TO + 10) @(posedge clk);
    chk("midrst_no_timeout", n_to - t0, 0);

`ifdef CMD_CHKSUM_EN
    c0 = n_chk;
    send_byte(8'h10, 1, 1'b0);
    send_byte(8'h20, 1, 1'b0);
    send_byte(8'h30, 1, 1'b0);
    send_byte(8'hA0, 1, 1'b0);
    settle();
    chk("chk_ok_cmd", cmd, 24'h102030);
    chk("chk_ok_rdy", cmd_rdy, 1);
    send_byte(8'h10, 1, 1'b0);
    send_byte(8'h20, 1, 1'b0);
    send_byte(8'h30, 1, 1'b0);
    send_byte(8'hA1, 1, 1'b0);
    settle();
    chk("chk_err_count", n_chk - c0, 1);
    chk("chk_err_rdy", cmd_rdy, 0);
    chk("chk_err_cmd", cmd, 24'h102030);
`else
    c0 = 0;
    chk("chk_err_tied", n_chk, c0);
`endif

    chk("no_double_ack", n_dbl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmd_rcv_ctrl.md
CMD_RCV_CTRL -- requirements
Module: cmd_rcv_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 1302000, meaning the number of clk cycles allowed between bytes of one command before abandoning it.
REQ-002 clk  input  1  system clock, 50 MHz; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_rdy  input  1  byte-available flag from the UART receiver.
REQ-005 rx_data  input  8  byte from the UART receiver, valid while rx_rdy=1.
REQ-006 clr_rx_rdy  output  1  one-cycle pulse acknowledging the byte to the UART receiver.
REQ-007 clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy.
REQ-008 cmd  output  24  assembled command {opcode[23:16], data_hi[15:8], data_lo[7:0]}.
REQ-009 cmd_rdy  output  1  level, high while cmd holds an unconsumed valid command.
REQ-010 timeout  output  1  one-cycle pulse when a partial command is abandoned.
REQ-011 chk_err  output  1  one-cycle pulse when a checksum mismatch occurs.

Function
REQ-012 The FSM SHALL have states WAIT_B0, WAIT_B1, WAIT_B2 and, only when CMD_CHKSUM_EN is defined, WAIT_CHK.
REQ-013 In any WAIT state with rx_rdy=1, the block SHALL assert clr_rx_rdy combinationally in that cycle, capture rx_data on that edge, and advance to the next state.
REQ-014 clr_rx_rdy SHALL never be high for two consecutive cycles.
REQ-015 The byte capture order SHALL be WAIT_B0 -> cmd[23:16], WAIT_B1 -> cmd[15:8], WAIT_B2 -> cmd[7:0].
REQ-016 The byte completing a command SHALL set cmd_rdy on the same edge that captures it; cmd SHALL be stable while cmd_rdy=1.
REQ-017 Capture of a new first byte in WAIT_B0 SHALL clear cmd_rdy; cmd[23:16] SHALL be written into a shadow register, and cmd SHALL update only on completion.
REQ-018 clr_cmd_rdy SHALL clear cmd_rdy; if set and clr_cmd_rdy coincide, cmd_rdy SHALL set.
REQ-019 The timeout counter SHALL clear on every captured byte and while in WAIT_B0, and SHALL increment otherwise.
REQ-020 In a non-WAIT_B0 state, when the count equals TIMEOUT_CYC-1 with no rx_rdy, the block SHALL pulse timeout, return to WAIT_B0 and discard the partial bytes; cmd and cmd_rdy SHALL be unchanged.
REQ-021 rx_rdy in the timeout cycle SHALL win: the byte is captured and no timeout occurs.
REQ-022 The counter width SHALL be $clog2(TIMEOUT_CYC+1) and the counter SHALL not wrap.
REQ-023 An illegal state SHALL go to WAIT_B0.

Reset
REQ-024 On rst_n=0 the block SHALL go to WAIT_B0 with cmd=24'h000000, cmd_rdy=0, clr_rx_rdy=0, timeout=0, chk_err=0 and counter=0.
REQ-025 Reset mid-command SHALL discard partial bytes, and no pulse SHALL follow release.

Configuration
REQ-026 The macro CMD_CHKSUM_EN SHALL add a fourth byte in WAIT_CHK; completion requires (b0+b1+b2+chk) mod 256 == 8'h00, at which point cmd_rdy is set.
REQ-027 With CMD_CHKSUM_EN and a mismatch, the block SHALL pulse chk_err, leave cmd and cmd_rdy unchanged, and go to WAIT_B0; timeout also applies in WAIT_CHK.
REQ-028 Without CMD_CHKSUM_EN, the command SHALL be 3 bytes, WAIT_B2 SHALL complete it, and chk_err SHALL be tied to 0.

Structure
REQ-029 Package cmd_ctrl_pkg SHALL hold the state_t enum, CMD_W=24 and the opcode localparams shared with the command decoder.
REQ-030 The timeout counter SHALL be sub-module cmd_tmr (clear, enable, terminal-count output, parameter TIMEOUT_CYC).

Verification
REQ-031 With TIMEOUT_CYC=50, bytes 8'hA5, 8'h12, 8'h34 with rx_rdy pulses 30 cycles apart -> cmd=24'hA51234, cmd_rdy=1 on the third capture edge, and exactly three clr_rx_rdy pulses.
REQ-032 With cmd_rdy=1 and clr_cmd_rdy asserted on the same edge as a completing capture of 8'h01, 8'h02, 8'h03 -> cmd_rdy stays 1 and cmd=24'h010203.
REQ-033 With bytes 8'h40, 8'h11 and then no byte for 50 cycles -> timeout pulses once on the 50th cycle, the state returns to WAIT_B0, and the prior cmd is unchanged.
REQ-034 With rx_rdy arriving exactly on cycle 49 -> no timeout and the byte is captured.
REQ-035 With rst_n low after 2 bytes, then a fresh 8'hC0, 8'h00, 8'h01 -> cmd=24'hC00001 and no timeout.
REQ-036 With CMD_CHKSUM_EN, bytes 8'h10, 8'h20, 8'h30, 8'hA0 -> cmd_rdy=1; with last byte 8'hA1 -> one chk_err pulse and cmd_rdy=0.
